// File: rtl/block_packer.sv
// block_packer
// Serial-to-block front end for the 5-lane block_filter. Collects five
// consecutive signed samples into a block, buffers blocks in a small FIFO and
// presents the head block on out0..out_4 (out0 newest, out_4 oldest).
// A flush pulse zero-pads and emits a trailing partial block.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   s_data/s_valid/s_ready : sample input handshake
//   flush               : one-cycle pulse, emit partial block
//   out0, out_1..out_4  : head block lanes (0 when blk_valid = 0)
//   blk_valid/blk_ready : block output handshake
//   fill                : samples held in the assembly register (0-4)

// Per-lane push value: lane L carries the k-th sample of the block, k = 4-L.
// The lane is populated only when at least k+1 samples are present; otherwise
// it is zero padding.
module block_packer_lane #(
  parameter int DW = 16,
  parameter int K  = 0
) (
  input  logic [DW-1:0] din,
  input  logic [2:0]    cnt,
  output logic [DW-1:0] val
);
  assign val = (cnt > 3'(K)) ? din : '0;
endmodule

module block_packer #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          flush,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out_1,
  output logic [DW-1:0] out_2,
  output logic [DW-1:0] out_3,
  output logic [DW-1:0] out_4,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [2:0]    fill
);

  localparam int NUM_LANES = 5;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [NUM_LANES-1:0][DW-1:0] blk_t;

  // Assembly register: slot k holds the k-th arrived sample.
  logic [3:0][DW-1:0] slot;
  logic [2:0]         fill_q;
  logic               flush_pend;

  // Block FIFO; entry index equals lane number.
  blk_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic full, accept, complete, pend_push, push, pop;
  logic [2:0] cnt;
  logic [NUM_LANES-1:0][DW-1:0] src;
  blk_t push_blk, head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  // Registered-state only: a pop this cycle cannot free space for a 5th sample.
  assign s_ready   = !flush_pend && ((fill_q != 3'd4) || !full);
  assign accept    = s_valid && s_ready;
  assign complete  = accept && (fill_q == 3'd4);
  assign pend_push = flush_pend && !full;
  assign push      = complete || pend_push;
  assign blk_valid = (count != '0);
  assign pop       = blk_valid && blk_ready;

  // Candidate sources for each sample position; position 4 is only ever the
  // incoming sample that completes a block.
  assign src = {s_data, slot};
  assign cnt = complete ? 3'd5 : fill_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    block_packer_lane #(.DW(DW), .K(NUM_LANES - 1 - l)) u_lane (
      .din (src[NUM_LANES-1-l]),
      .cnt (cnt),
      .val (push_blk[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot       <= '0;
      fill_q     <= '0;
      flush_pend <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_blk;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (complete) begin
        fill_q <= '0;
      end else if (accept) begin
        slot[fill_q[1:0]] <= s_data;
        fill_q            <= fill_q + 3'd1;
      end

      // Pending flush drains first; a new flush pulse during it is redundant.
      // A flush on a completing sample has nothing left to pad.
      if (pend_push) begin
        fill_q     <= '0;
        flush_pend <= 1'b0;
      end else if (flush && !complete && (accept || fill_q != 3'd0)) begin
        flush_pend <= 1'b1;
      end
    end
  end

  assign head  = blk_valid ? mem[rd_ptr] : '0;
  assign out0  = head[0];
  assign out_1 = head[1];
  assign out_2 = head[2];
  assign out_3 = head[3];
  assign out_4 = head[4];
  assign fill  = fill_q;

endmodule

// File: tb/tb_block_packer.sv
module tb_block_packer;
  localparam int DW = 16;
  localparam int DEPTH = 2;

  logic clk = 0, reset = 0;
  logic [DW-1:0] s_data = '0;
  logic s_valid = 0, flush = 0, blk_ready = 0;
  logic s_ready, blk_valid;
  logic [DW-1:0] out0, out_1, out_2, out_3, out_4;
  logic [2:0] fill;

  int errors = 0, checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  block_packer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .out0(out0), .out_1(out_1),
    .out_2(out_2), .out_3(out_3), .out_4(out_4), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .fill(fill)
  );

  // ---------------- reference model: queues of samples and blocks ----------
  typedef logic [4:0][DW-1:0] blk_t;   // index = lane number
  blk_t mq[$];
  logic [DW-1:0] cur[$];
  bit m_pend = 0;

  function automatic blk_t mk(input logic [DW-1:0] q[$]);
    blk_t b = '0;
    foreach (q[k]) b[4-k] = q[k];
    return b;
  endfunction

  always @(posedge clk) begin
    bit rdy, full0, pend0, done;
    if (!reset) begin
      mq.delete(); cur.delete(); m_pend = 0;
    end else begin
      rdy   = !m_pend && (cur.size() != 4 || mq.size() < DEPTH);
      full0 = (mq.size() == DEPTH);
      pend0 = m_pend;
      done  = 0;
      if (mq.size() != 0 && blk_ready) void'(mq.pop_front());
      if (pend0) begin
        if (!full0) begin
          mq.push_back(mk(cur)); cur.delete(); m_pend = 0;
        end
      end else if (s_valid && rdy) begin
        cur.push_back(s_data);
        if (cur.size() == 5) begin
          mq.push_back(mk(cur)); cur.delete(); done = 1;
        end
      end
      if (flush && !pend0 && !done && cur.size() > 0) m_pend = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string nm, input int e4, e3, e2, e1, e0);
    blk_t a, e;
    a = {out_4, out_3, out_2, out_1, out0};
    e = {DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    checks++;
    if (a !== e || blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: got vld=%b %h expected vld=1 %h", nm, blk_valid, a, e);
    end
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    blk_t eh;
    if (chk_en) begin
      eh = (mq.size() != 0) ? mq[0] : '0;
      chk("m_s_ready", 32'(s_ready), 32'(!m_pend && (cur.size() != 4 || mq.size() < DEPTH)));
      chk("m_blk_valid", 32'(blk_valid), 32'(mq.size() != 0));
      chk("m_fill", 32'(fill), 32'(cur.size()));
      checks++;
      if ({out_4, out_3, out_2, out_1, out0} !== eh) begin
        errors++;
        $display("FAIL m_lanes: got %h expected %h at %0t",
                 {out_4, out_3, out_2, out_1, out0}, eh, $time);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a sample and hold until it is accepted (bounded). s_valid stays
  // high on return so back-to-back sends stream at full rate.
  task automatic send(input int v);
    bit r;
    int tries = 0;
    s_data = DW'(v); s_valid = 1;
    do begin
      @(negedge clk); r = s_ready;
      @(posedge clk); #1;
      tries++;
    end while (!r && tries < 50);
    if (!r) chk("send_timeout", 32'(tries), 32'(0));
  endtask

  initial begin
    // Reset
    reset = 0; tick(2);
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_lanes", 32'(out_4 | out0), 32'd0);
    reset = 1; chk_en = 1;

    // Ordered stream with the consumer always ready
    blk_ready = 1;
    for (int i = 1; i <= 5; i++) send(i);
    chk_head("ord_blk1", 1, 2, 3, 4, 5);
    for (int i = 6; i <= 10; i++) send(i);
    chk_head("ord_blk2", 6, 7, 8, 9, 10);
    s_valid = 0; tick(3);

    // Backpressure: two blocks buffered, four held, 15th sample stalls
    blk_ready = 0;
    for (int i = 1; i <= 14; i++) send(i);
    s_data = DW'(15); s_valid = 1;
    tick(3);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_fill", 32'(fill), 32'd4);
    chk_head("bp_head", 1, 2, 3, 4, 5);
    blk_ready = 1;
    tick(1);
    chk_head("bp_drain2", 6, 7, 8, 9, 10);
    tick(1);
    s_valid = 0;
    chk_head("bp_drain3", 11, 12, 13, 14, 15);
    tick(3);
    chk("bp_empty", 32'(blk_valid), 32'd0);

    // Partial block via flush
    blk_ready = 0;
    send(-3); send(7);
    s_valid = 0; flush = 1;
    tick(1);
    flush = 0;
    chk("fl_pend_vld", 32'(blk_valid), 32'd0);
    chk("fl_pend_rdy", 32'(s_ready), 32'd0);
    tick(1);
    chk_head("fl_partial", 16'hFFFD, 7, 0, 0, 0);
    chk("fl_fill", 32'(fill), 32'd0);
    blk_ready = 1; tick(1); blk_ready = 0;

    // Flush with nothing held
    flush = 1; tick(1); flush = 0;
    tick(3);
    chk("fl_empty", 32'(blk_valid), 32'd0);

    // Flush on the completing 5th sample
    for (int i = 1; i <= 4; i++) send(i);
    s_data = DW'(5); flush = 1;
    tick(1);
    flush = 0; s_valid = 0;
    chk_head("fl_5th", 1, 2, 3, 4, 5);
    tick(3);
    blk_ready = 1; tick(1); blk_ready = 0;
    tick(3);
    chk("fl_5th_single", 32'(blk_valid), 32'd0);

    // Reset mid-operation
    for (int i = 1; i <= 13; i++) send(i);
    s_valid = 0;
    chk("mr_fill", 32'(fill), 32'd3);
    chk("mr_full_rdy", 32'(s_ready), 32'd1);
    reset = 0; tick(1);
    chk("mr_blk_valid", 32'(blk_valid), 32'd0);
    chk("mr_fill0", 32'(fill), 32'd0);
    chk("mr_s_ready", 32'(s_ready), 32'd1);
    reset = 1;
    for (int i = 21; i <= 25; i++) send(i);
    s_valid = 0;
    chk_head("mr_clean", 21, 22, 23, 24, 25);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/block_packer.md
# block_packer

Serial-to-block front end for the 5-lane parallel FIR `block_filter`. It accepts one signed sample per cycle over a valid/ready handshake and assembles five consecutive samples into a block. Blocks are buffered in a small FIFO and presented on the lanes `out0`, `out_1` … `out_4` with block-level valid/ready, in the lane order `block_filter` expects on `in0`, `in_1` … `in_4`. A flush input pads and emits a trailing partial block at end of stream.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `DEPTH`, 2: block FIFO depth in blocks (≥1).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; low on a rising edge resets the block.
- `s_data` in DW: input sample.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: block can accept a sample this cycle.
- `flush` in 1: one-cycle pulse; emit the partial block zero-padded.
- `out0`, `out_1`, `out_2`, `out_3`, `out_4` out DW each: head block lanes. `out0` is the newest sample, `out_4` the oldest.
- `blk_valid` out 1: head block is valid.
- `blk_ready` in 1: consumer takes the head block.
- `fill` out 3: samples held in the assembly register, 0–4.

## Operation
- **Assembly register:** slots 0–3 plus `fill` counter.
- **Accept:** a sample is accepted when `s_valid && s_ready`.
  - If `fill < 4`: store in slot `fill`, then `fill++`.
  - If `fill == 4`: the sample completes the block. Push {slot0..slot3, sample} to the FIFO and set `fill` to 0.
- **Lane mapping:** the k-th arrived sample of a block (k = 0 first) drives lane `out_(4-k)`. Sample 0 goes to `out_4`; sample 4 goes to `out0`.
- **`s_ready`:** `(fill != 4) || (fifo_count < DEPTH)`. It depends only on registered state; there is no combinational path from `blk_ready`.
- **FIFO pop:** on `blk_valid && blk_ready`.
- **Flush:**
  - Sets `flush_pend` when `fill > 0`, or when a sample is accepted in the same cycle.
  - While `flush_pend` and FIFO not full, push the partial block: filled samples keep the mapping above, and the unfilled newer lanes are 0. Then clear `fill` and `flush_pend`.
  - While `flush_pend` is set, `s_ready` is 0.
  - Flush with `fill == 0` and no accept in that cycle is ignored; no empty block is ever pushed.
  - A flush in the same cycle as a completing 5th sample produces exactly one full block and no extra block.
- **Simultaneous push and pop:**
  - Allowed when the FIFO is not full; `fifo_count` is unchanged.
  - When full, push is blocked by `s_ready = 0` even if a pop occurs that cycle. This costs one bubble, which is accepted.
- **Width:** data is not modified. Padding is zero, not sign-extended.
- **Idle outputs:** lanes read 0 when `blk_valid = 0`.

## Timing
- **Reset values:** `fill` 0, FIFO empty, `flush_pend` 0, `blk_valid` 0, all lanes 0, `s_ready` 1.
- **Reset mid-operation:** discards the partial block and all buffered blocks on that edge.
- **Latency:** the completing sample is accepted at edge N; `blk_valid` is 1 after edge N with that block at the head if the FIFO was empty.
- **Flush latency:** pulse at edge N with FIFO space → partial block valid after edge N+1 (the pend cycle).
- **Throughput:** 1 sample/cycle sustained, one block per 5 cycles with `blk_ready` held 1.
- **Head stability:** lanes and `blk_valid` hold steady while `blk_valid && !blk_ready`.

## Test plan
- **Ordered stream:** reset, stream 1,2,3,…,10 with `blk_ready = 1`.
  - Two blocks appear.
  - Block 1: `out4..out0` = 1,2,3,4,5. Block 2: 6..10.
  - Each block is valid one cycle after its 5th sample; `s_ready` never drops.
- **Backpressure:** `blk_ready = 0`, stream 15 samples.
  - FIFO holds 2 blocks, `fill` reaches 4, then `s_ready = 0` with the 15th sample (value 15) stalled.
  - Raising `blk_ready` drains 1–5, then 6–10, then 11–15, with no loss or duplication.
- **Flush, partial block:** send -3, 7, then a `flush` pulse.
  - One block: `out_4 = -3` (0xFFFD), `out_3 = 7`, `out_2 = out_1 = out0 = 0`.
  - `fill` returns to 0.
- **Flush corner cases:**
  - `flush` with `fill = 0` → no block.
  - `flush` coinciding with the 5th sample (values 1–5) → exactly one block, 1–5.
- **Reset mid-operation:** with 2 blocks buffered and `fill = 3`, pull `reset` low for one edge.
  - `blk_valid = 0`, `fill = 0`, `s_ready = 1`.
  - The next 5 samples form a clean block.
